// File: rtl/a1339_spi_responder.sv
// A1339 angle-sensor emulator: SPI mode-3 slave answering 20-bit read frames with
// angle/turns data, status, error flags and a 4-bit CRC, one frame of command latency.
module a1339_spi_responder #(
  parameter int unsigned FRAME_BITS  = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sck_i,
  input  logic        ss_n_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe,
  input  logic [11:0] angle_i,
  input  logic [11:0] turns_i,
  input  logic [1:0]  status_i,
  output logic [15:0] cmd_o,
  output logic        cmd_valid_o,
  output logic        crc_error_o,
  output logic        abort_o,
  output logic [15:0] frame_count_o
);

  localparam int unsigned TX_W   = 20;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned DATA_W = 12;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_FINISH} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ss_prev_q, ss_prev_d;
  logic [TX_W-1:0]        tx_q, tx_d;
  logic [TX_W-1:0]        rx_q, rx_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic [WORD_W-1:0]      cmd_q, cmd_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   crc_error_q, crc_error_d;
  logic                   abort_q, abort_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [3:0]             pend_addr_q, pend_addr_d;
  logic                   err_crc_q, err_crc_d;

  logic              sck_s, ss_s, mosi_s;
  logic              sck_fall, sck_rise, ss_fall, ss_rise;
  logic [DATA_W-1:0] resp_data;
  logic              err_addr;
  logic [WORD_W-1:0] resp_word;
  logic              rx_crc_ok;

  // Sensor CRC: x^4+x+1, seed 0xF, MSB first
  function automatic logic [3:0] crc4(input logic [WORD_W-1:0] w);
    logic [3:0] c;
    logic       inv;
    c = 4'hF;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      inv = w[i] ^ c[3];
      c   = {c[2], c[1], c[0] ^ inv, inv};
    end
    return c;
  endfunction

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
    sck_fall    = sck_prev_q & ~sck_s;
    sck_rise    = ~sck_prev_q & sck_s;
    ss_fall     = ss_prev_q & ~ss_s;
    ss_rise     = ~ss_prev_q & ss_s;
  end

  // Response selected by the command accepted in the previous frame
  always_comb begin
    resp_data = '0;
    err_addr  = 1'b0;
    case (pend_addr_q)
      4'h0:    resp_data = angle_i;
      4'hC:    resp_data = turns_i;
      default: err_addr  = 1'b1;
    endcase
    resp_word = {err_crc_q, err_addr, status_i, resp_data};
    rx_crc_ok = (crc4(rx_q[TX_W-1:4]) == rx_q[3:0]);
  end

  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    bit_cnt_d     = bit_cnt_q;
    miso_d        = miso_q;
    miso_oe_d     = ~ss_s;
    cmd_d         = cmd_q;
    cmd_valid_d   = 1'b0;
    crc_error_d   = 1'b0;
    abort_d       = 1'b0;
    frame_count_d = frame_count_q;
    pend_addr_d   = pend_addr_q;
    err_crc_d     = err_crc_q;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b1;
        if (ss_fall) begin
          state_d   = ST_SHIFT;
          tx_d      = {resp_word, crc4(resp_word)};
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_FINISH;
        end else begin
          if (sck_fall) begin
            miso_d = tx_q[TX_W-1];
            tx_d   = {tx_q[TX_W-2:0], 1'b0};
          end
          if (sck_rise) begin
            rx_d = {rx_q[TX_W-2:0], mosi_s};
            if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        miso_d  = 1'b1;
        if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
          frame_count_d = frame_count_q + 16'd1;
          if (!rx_crc_ok) begin
            crc_error_d = 1'b1;
            err_crc_d   = 1'b1;
          end else begin
            err_crc_d   = 1'b0;
            cmd_d       = rx_q[TX_W-1:4];
            cmd_valid_d = 1'b1;
            if (rx_q[19:16] == 4'h2) pend_addr_d = rx_q[15:12];
          end
        end else begin
          abort_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sck_sync_q    <= '1;
      ss_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sck_prev_q    <= 1'b1;
      ss_prev_q     <= 1'b1;
      tx_q          <= '0;
      rx_q          <= '0;
      bit_cnt_q     <= '0;
      miso_q        <= 1'b1;
      miso_oe_q     <= 1'b0;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      crc_error_q   <= 1'b0;
      abort_q       <= 1'b0;
      frame_count_q <= '0;
      pend_addr_q   <= 4'h0;
      err_crc_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sck_prev_q    <= sck_prev_d;
      ss_prev_q     <= ss_prev_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      bit_cnt_q     <= bit_cnt_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      crc_error_q   <= crc_error_d;
      abort_q       <= abort_d;
      frame_count_q <= frame_count_d;
      pend_addr_q   <= pend_addr_d;
      err_crc_q     <= err_crc_d;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe       = miso_oe_q;
  assign cmd_o         = cmd_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign crc_error_o   = crc_error_q;
  assign abort_o       = abort_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_a1339_spi_responder.sv
// Bench for a1339_spi_responder: a mode-3 SPI master, a sensor reference model and a
// queue of expected response frames checked as each frame is clocked out.
module tb_a1339_spi_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        sck_i, ss_n_i, mosi_i;
  logic        miso_o, miso_oe;
  logic [11:0] angle_i, turns_i;
  logic [1:0]  status_i;
  logic [15:0] cmd_o, frame_count_o;
  logic        cmd_valid_o, crc_error_o, abort_o;

  a1339_spi_responder #(.FRAME_BITS(20), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .sck_i(sck_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe(miso_oe), .angle_i(angle_i), .turns_i(turns_i),
    .status_i(status_i), .cmd_o(cmd_o), .cmd_valid_o(cmd_valid_o),
    .crc_error_o(crc_error_o), .abort_o(abort_o), .frame_count_o(frame_count_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int n_valid = 0, n_crc = 0, n_abort = 0;
  int d_valid, d_crc, d_abort;

  always @(negedge clock) begin
    if (cmd_valid_o) n_valid++;
    if (crc_error_o) n_crc++;
    if (abort_o)     n_abort++;
  end

  // Reference model state
  logic [3:0]  m_pend;
  logic        m_err;
  logic [15:0] m_cmd;
  logic [15:0] m_fc;
  logic [19:0] exp_q[$];

  function automatic logic [3:0] ref_crc(input logic [15:0] w);
    logic [3:0] c;
    logic       fb;
    c = 4'hF;
    for (int i = 15; i >= 0; i--) begin
      fb = w[i] ^ c[3];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic [19:0] exp_resp(input logic [3:0] pend, input logic err,
                                           input logic [11:0] ang, input logic [11:0] trn,
                                           input logic [1:0] st);
    logic [11:0] data;
    logic        ea;
    logic [15:0] w;
    data = (pend == 4'h0) ? ang : ((pend == 4'hC) ? trn : 12'h000);
    ea   = !((pend == 4'h0) || (pend == 4'hC));
    w    = {err, ea, st, data};
    return {w, ref_crc(w)};
  endfunction

  // One master transaction; pushes the expected response and updates the model
  task automatic spi_frame(input logic [19:0] mo, input int nbits, input int chg_bit,
                           input logic [11:0] chg_angle, output logic [19:0] mi);
    int v0, c0, a0;
    v0 = n_valid; c0 = n_crc; a0 = n_abort;
    mi = '0;
    @(negedge clock);
    exp_q.push_back(exp_resp(m_pend, m_err, angle_i, turns_i, status_i));
    ss_n_i = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      sck_i  = 1'b0;
      mosi_i = (i < 20) ? mo[19-i] : 1'b0;
      if (i == chg_bit) angle_i = chg_angle;
      repeat (8) @(negedge clock);
      if (i < 20) mi = {mi[18:0], miso_o};
      sck_i = 1'b1;
      repeat (8) @(negedge clock);
    end
    ss_n_i = 1'b1;
    repeat (10) @(negedge clock);
    if (nbits == 20) begin
      m_fc = m_fc + 16'd1;
      if (ref_crc(mo[19:4]) != mo[3:0]) begin
        m_err = 1'b1;
      end else begin
        m_err = 1'b0;
        m_cmd = mo[19:4];
        if (mo[19:16] == 4'h2) m_pend = mo[15:12];
      end
    end
    d_valid = n_valid - v0; d_crc = n_crc - c0; d_abort = n_abort - a0;
  endtask

  task automatic model_reset();
    m_pend = 4'h0; m_err = 1'b0; m_cmd = 16'h0000; m_fc = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1; sck_i = 1'b1; ss_n_i = 1'b1; mosi_i = 1'b0;
    angle_i = 12'h123; turns_i = 12'h000; status_i = 2'b00;
    model_reset();
    repeat (4) @(negedge clock);
    total++; if (miso_o !== 1'b1) begin bad++; $display("FAIL reset_miso got=%b exp=1", miso_o); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", miso_oe); end
    total++; if (cmd_o !== 16'h0000) begin bad++; $display("FAIL reset_cmd got=%h exp=0000", cmd_o); end
    total++; if ({cmd_valid_o, crc_error_o, abort_o} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {cmd_valid_o, crc_error_o, abort_o}); end
    total++; if (frame_count_o !== 16'h0000) begin bad++; $display("FAIL reset_fc got=%h exp=0000", frame_count_o); end
    reset = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_read_angle();
    logic [19:0] mi, ex;
    spi_frame(20'h20009, 20, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL angle_frame got=%h exp=%h", mi, ex); end
    total++; if (mi !== 20'h0123D) begin bad++; $display("FAIL angle_literal got=%h exp=0123D", mi); end
    total++; if (cmd_o !== 16'h2000) begin bad++; $display("FAIL angle_cmd got=%h exp=2000", cmd_o); end
    total++; if (d_valid !== 1) begin bad++; $display("FAIL angle_valid got=%0d exp=1", d_valid); end
    total++; if (frame_count_o !== 16'h0001) begin bad++; $display("FAIL angle_fc got=%h exp=0001", frame_count_o); end
  endtask

  task automatic test_read_turns();
    logic [19:0] mi, ex;
    turns_i = 12'hFFE;
    spi_frame(20'h2C001, 20, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL turns_first got=%h exp=%h", mi, ex); end
    spi_frame(20'h20009, 20, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL turns_second got=%h exp=%h", mi, ex); end
    total++; if (mi[15:4] !== 12'hFFE) begin bad++; $display("FAIL turns_data got=%h exp=FFE", mi[15:4]); end
    total++; if (mi[19:18] !== 2'b00) begin bad++; $display("FAIL turns_flags got=%b exp=00", mi[19:18]); end
    total++; if (mi[3:0] !== ref_crc(mi[19:4])) begin bad++; $display("FAIL turns_crc got=%h exp=%h", mi[3:0], ref_crc(mi[19:4])); end
    total++; if (cmd_o !== m_cmd) begin bad++; $display("FAIL turns_cmd got=%h exp=%h", cmd_o, m_cmd); end
  endtask

  task automatic test_crc_error();
    logic [19:0] mi, ex;
    spi_frame(20'h20008, 20, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL crc_frame got=%h exp=%h", mi, ex); end
    total++; if (d_crc !== 1) begin bad++; $display("FAIL crc_pulse got=%0d exp=1", d_crc); end
    total++; if (d_valid !== 0) begin bad++; $display("FAIL crc_valid got=%0d exp=0", d_valid); end
    total++; if (cmd_o !== 16'h2000) begin bad++; $display("FAIL crc_cmd got=%h exp=2000", cmd_o); end
    spi_frame(20'h20009, 20, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL crc_next got=%h exp=%h", mi, ex); end
    total++; if (mi[19] !== 1'b1) begin bad++; $display("FAIL crc_flag got=%b exp=1", mi[19]); end
    total++; if (mi[15:4] !== angle_i) begin bad++; $display("FAIL crc_data got=%h exp=%h", mi[15:4], angle_i); end
  endtask

  task automatic test_abort();
    logic [19:0] mi, ex;
    logic [15:0] fc0;
    spi_frame(20'h2C001, 20, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL abort_setup got=%h exp=%h", mi, ex); end
    fc0 = frame_count_o;
    spi_frame(20'h20009, 11, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== 20'(ex >> 9)) begin bad++; $display("FAIL abort_partial got=%h exp=%h", mi, 20'(ex >> 9)); end
    total++; if (d_abort !== 1) begin bad++; $display("FAIL abort_pulse got=%0d exp=1", d_abort); end
    total++; if (frame_count_o !== fc0) begin bad++; $display("FAIL abort_fc got=%h exp=%h", frame_count_o, fc0); end
    spi_frame(20'h20009, 25, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL long_frame got=%h exp=%h", mi, ex); end
    total++; if (d_abort !== 1 || d_valid !== 0) begin bad++; $display("FAIL long_pulses got=%0d/%0d exp=1/0", d_abort, d_valid); end
    spi_frame(20'h20009, 20, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL abort_after got=%h exp=%h", mi, ex); end
    total++; if (mi[15:4] !== 12'hFFE) begin bad++; $display("FAIL abort_pending got=%h exp=FFE", mi[15:4]); end
  endtask

  task automatic test_idle_sck();
    int v0, c0, a0;
    v0 = n_valid; c0 = n_crc; a0 = n_abort;
    for (int i = 0; i < 6; i++) begin
      sck_i = 1'b0; mosi_i = 1'(i); repeat (8) @(negedge clock);
      sck_i = 1'b1; repeat (8) @(negedge clock);
    end
    total++; if ((n_valid - v0) + (n_crc - c0) + (n_abort - a0) !== 0) begin bad++; $display("FAIL idle_pulses got=%0d exp=0", (n_valid - v0) + (n_crc - c0) + (n_abort - a0)); end
    total++; if (miso_o !== 1'b1) begin bad++; $display("FAIL idle_miso got=%b exp=1", miso_o); end
    total++; if (frame_count_o !== m_fc) begin bad++; $display("FAIL idle_fc got=%h exp=%h", frame_count_o, m_fc); end
    ss_n_i = 1'b0;
    repeat (8) @(negedge clock);
    total++; if (miso_oe !== 1'b1) begin bad++; $display("FAIL sel_oe got=%b exp=1", miso_oe); end
    ss_n_i = 1'b1;
    repeat (10) @(negedge clock);
    total++; if (n_abort - a0 !== 1) begin bad++; $display("FAIL empty_abort got=%0d exp=1", n_abort - a0); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL desel_oe got=%b exp=0", miso_oe); end
  endtask

  task automatic test_angle_change();
    logic [19:0] mi, ex;
    angle_i = 12'h100;
    repeat (2) @(negedge clock);
    spi_frame(20'h20009, 20, 5, 12'h200, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL snap_frame got=%h exp=%h", mi, ex); end
    total++; if (mi[15:4] !== 12'h100) begin bad++; $display("FAIL snap_old got=%h exp=100", mi[15:4]); end
    spi_frame(20'h20009, 20, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL snap_next got=%h exp=%h", mi, ex); end
    total++; if (mi[15:4] !== 12'h200) begin bad++; $display("FAIL snap_new got=%h exp=200", mi[15:4]); end
  endtask

  task automatic test_wrap_and_reset();
    logic [19:0] mi, ex;
    int v0, c0, a0;
    force dut.frame_count_q = 16'hFFFF;
    repeat (2) @(negedge clock);
    release dut.frame_count_q;
    repeat (2) @(negedge clock);
    m_fc = 16'hFFFF;
    total++; if (frame_count_o !== 16'hFFFF) begin bad++; $display("FAIL preload_fc got=%h exp=FFFF", frame_count_o); end
    spi_frame(20'h2C001, 20, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL wrap_frame got=%h exp=%h", mi, ex); end
    total++; if (frame_count_o !== 16'h0000) begin bad++; $display("FAIL wrap_fc got=%h exp=0000", frame_count_o); end
    // Partial frame interrupted by reset
    v0 = n_valid; c0 = n_crc; a0 = n_abort;
    ss_n_i = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      sck_i = 1'b0; mosi_i = 1'b1; repeat (8) @(negedge clock);
      sck_i = 1'b1; repeat (8) @(negedge clock);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", miso_oe); end
    total++; if (miso_o !== 1'b1) begin bad++; $display("FAIL rst_miso got=%b exp=1", miso_o); end
    ss_n_i = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    model_reset();
    repeat (10) @(negedge clock);
    total++; if ((n_valid - v0) + (n_crc - c0) + (n_abort - a0) !== 0) begin bad++; $display("FAIL rst_pulses got=%0d exp=0", (n_valid - v0) + (n_crc - c0) + (n_abort - a0)); end
    total++; if (cmd_o !== 16'h0000 || frame_count_o !== 16'h0000) begin bad++; $display("FAIL rst_regs got=%h/%h exp=0000/0000", cmd_o, frame_count_o); end
    spi_frame(20'h20009, 20, -1, 12'h0, mi);
    ex = exp_q.pop_front();
    total++; if (mi !== ex) begin bad++; $display("FAIL rst_next got=%h exp=%h", mi, ex); end
    total++; if (mi[15:4] !== angle_i) begin bad++; $display("FAIL rst_angle got=%h exp=%h", mi[15:4], angle_i); end
  endtask

  initial begin
    test_reset();
    test_read_angle();
    test_read_turns();
    test_crc_error();
    test_abort();
    test_idle_sck();
    test_angle_change();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
